// File: rtl/forwarding_scoreboard.sv
// Forwarding scoreboard: tracks in-flight writers in the EX slot plus DEPTH
// downstream stages, produces per-source ALU operand forwarding selects for
// the EX instruction and detects load-use hazards (ID/IF stall + EX bubble).
// Optional build macro: FWD_PERF_CNT_EN adds stall / forwarding event counters.
module forwarding_scoreboard #(
  parameter int unsigned RA_W     = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LOAD_LAT = 1,
  localparam int unsigned SEL_W   = $clog2(DEPTH + 2)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NUM_SRC*RA_W-1:0]  id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic [RA_W-1:0]          id_rd,
  input  logic                     id_reg_write,
  input  logic                     id_is_load,
  input  logic                     flush,
  output logic                     stall,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     ex_valid,
  output logic [DEPTH-1:0]         stage_valid
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_fwd_cnt
`endif
);

  // EX slot
  logic                    ex_valid_q;
  logic [NUM_SRC*RA_W-1:0] ex_src_q;
  logic [NUM_SRC-1:0]      ex_used_q;
  logic [RA_W-1:0]         ex_rd_q;
  logic                    ex_rw_q;
  logic                    ex_ld_q;

  // Downstream stages, index k-1 holds stage k
  logic [DEPTH-1:0]           st_valid_q;
  logic [DEPTH-1:0][RA_W-1:0] st_rd_q;
  logic [DEPTH-1:0]           st_rw_q;
  logic [DEPTH-1:0]           st_ld_q;

  logic hazard;

  // Load-use hazard on the ID instruction against loads not yet forwardable
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (id_src_used[i] && (id_src[i*RA_W +: RA_W] != '0)) begin
        if (ex_valid_q && ex_rw_q && ex_ld_q && (ex_rd_q == id_src[i*RA_W +: RA_W])) begin
          hazard = 1'b1;
        end
        for (int k = 1; k <= int'(DEPTH); k++) begin
          if ((k < int'(LOAD_LAT)) && st_valid_q[k-1] && st_rw_q[k-1] && st_ld_q[k-1] &&
              (st_rd_q[k-1] == id_src[i*RA_W +: RA_W])) begin
            hazard = 1'b1;
          end
        end
      end
    end
    // flush squashes the ID instruction, so it never needs to wait
    stall = id_valid && !flush && hazard;
  end

  // Forwarding selects from registered state only; youngest matching stage wins
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (ex_valid_q && ex_used_q[i]) begin
        if (ex_src_q[i*RA_W +: RA_W] == '0) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(DEPTH + 1);
        end else begin
          // Scan oldest to youngest so the youngest match is the last write
          for (int k = int'(DEPTH); k >= 1; k--) begin
            if (st_valid_q[k-1] && st_rw_q[k-1] && (st_rd_q[k-1] != '0) &&
                (st_rd_q[k-1] == ex_src_q[i*RA_W +: RA_W])) begin
              fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
            end
          end
        end
      end
    end
  end

  // EX slot load: bubble on flush or stall, otherwise capture ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_src_q   <= '0;
      ex_used_q  <= '0;
      ex_rd_q    <= '0;
      ex_rw_q    <= 1'b0;
      ex_ld_q    <= 1'b0;
    end else if (flush || stall) begin
      ex_valid_q <= 1'b0;
      ex_src_q   <= '0;
      ex_used_q  <= '0;
      ex_rd_q    <= '0;
      ex_rw_q    <= 1'b0;
      ex_ld_q    <= 1'b0;
    end else begin
      ex_valid_q <= id_valid;
      ex_src_q   <= id_src;
      ex_used_q  <= id_src_used;
      ex_rd_q    <= id_rd;
      ex_rw_q    <= id_reg_write;
      ex_ld_q    <= id_is_load;
    end
  end

  // Downstream shift pipeline; never stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid_q <= '0;
      st_rd_q    <= '0;
      st_rw_q    <= '0;
      st_ld_q    <= '0;
    end else begin
      st_valid_q[0] <= ex_valid_q;
      st_rd_q[0]    <= ex_rd_q;
      st_rw_q[0]    <= ex_rw_q;
      st_ld_q[0]    <= ex_ld_q;
      for (int k = 1; k < int'(DEPTH); k++) begin
        st_valid_q[k] <= st_valid_q[k-1];
        st_rd_q[k]    <= st_rd_q[k-1];
        st_rw_q[k]    <= st_rw_q[k-1];
        st_ld_q[k]    <= st_ld_q[k-1];
      end
    end
  end

  assign ex_valid    = ex_valid_q;
  assign stage_valid = st_valid_q;

`ifdef FWD_PERF_CNT_EN
  logic fwd_any;

  // Any source currently taking a pipeline stage (not regfile, not zero)
  always_comb begin
    fwd_any = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if ((fwd_sel[i*SEL_W +: SEL_W] != '0) &&
          (fwd_sel[i*SEL_W +: SEL_W] <= SEL_W'(DEPTH))) begin
        fwd_any = 1'b1;
      end
    end
  end

  // Saturating event counters, only cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (fwd_any && (perf_fwd_cnt != 32'hFFFF_FFFF)) begin
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard with default parameters
// (RA_W=5, NUM_SRC=2, DEPTH=2, LOAD_LAT=1). Honours FWD_PERF_CNT_EN.
module tb_forwarding_scoreboard;

  localparam int unsigned RA_W    = 5;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned SEL_W   = 2;

  logic                     clk;
  logic                     rst_n;
  logic                     id_valid;
  logic [NUM_SRC*RA_W-1:0]  id_src;
  logic [NUM_SRC-1:0]       id_src_used;
  logic [RA_W-1:0]          id_rd;
  logic                     id_reg_write;
  logic                     id_is_load;
  logic                     flush;
  logic                     stall;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     ex_valid;
  logic [DEPTH-1:0]         stage_valid;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]              perf_stall_cnt;
  logic [31:0]              perf_fwd_cnt;
`endif

  int checks;
  int failures;

  forwarding_scoreboard #(
    .RA_W     (RA_W),
    .NUM_SRC  (NUM_SRC),
    .DEPTH    (DEPTH),
    .LOAD_LAT (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .stall        (stall),
    .fwd_sel      (fwd_sel),
    .ex_valid     (ex_valid),
    .stage_valid  (stage_valid)
`ifdef FWD_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_fwd_cnt   (perf_fwd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SEL_W-1:0] sel_of(input int i);
    return fwd_sel[i*SEL_W +: SEL_W];
  endfunction

  task automatic drive(input logic v, input logic [RA_W-1:0] s0, input logic [RA_W-1:0] s1,
                       input logic [1:0] used, input logic [RA_W-1:0] rd, input logic rw,
                       input logic ld, input logic fl);
    id_valid     = v;
    id_src       = {s1, s0};
    id_src_used  = used;
    id_rd        = rd;
    id_reg_write = rw;
    id_is_load   = ld;
    flush        = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one edge; leaves time 1 unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH + 1) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #2;
    checks++;
    if (stall !== 1'b0 || ex_valid !== 1'b0 || stage_valid !== 2'b00 || fwd_sel !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got stall=%b ex_valid=%b stage_valid=%b fwd_sel=%b, want 0/0/00/0000",
               stall, ex_valid, stage_valid, fwd_sel);
    end
`ifdef FWD_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== 32'd0 || perf_fwd_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_perf: got %0d/%0d, want 0/0", perf_stall_cnt, perf_fwd_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || stage_valid !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: got ex_valid=%b stage_valid=%b, want 0/00",
               ex_valid, stage_valid);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);  // add r3
    tick();
    drive(1'b1, 5'd3, 5'd1, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0);  // reads r3, r1
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_stall: got stall=%b, want 0", stall);
    end
    tick();
    idle();
    #1;
    checks++;
    if (sel_of(0) !== 2'b01 || sel_of(1) !== 2'b00) begin
      failures++;
      $display("FAIL b2b_fwd: got src0=%b src1=%b, want 01/00", sel_of(0), sel_of(1));
    end
    checks++;
    if (ex_valid !== 1'b1 || stage_valid !== 2'b01) begin
      failures++;
      $display("FAIL b2b_valid: got ex_valid=%b stage_valid=%b, want 1/01", ex_valid, stage_valid);
    end
    drain();
  endtask

  task automatic test_two_ago();
    drive(1'b1, 5'd1, 5'd1, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd2, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd5, 2'b10, 5'd9, 1'b1, 1'b0, 1'b0);  // src0 r5 but unused
    tick();
    idle();
    #1;
    checks++;
    if (sel_of(1) !== 2'b01 || sel_of(0) !== 2'b00) begin
      failures++;
      $display("FAIL two_ago_youngest: got src0=%b src1=%b, want 00/01", sel_of(0), sel_of(1));
    end
    checks++;
    if (stage_valid !== 2'b11) begin
      failures++;
      $display("FAIL two_ago_stages: got stage_valid=%b, want 11", stage_valid);
    end
    // One cycle later the reader has left EX
    tick();
    checks++;
    if (fwd_sel !== 4'b0000 || ex_valid !== 1'b0) begin
      failures++;
      $display("FAIL two_ago_drain: got fwd_sel=%b ex_valid=%b, want 0000/0", fwd_sel, ex_valid);
    end
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd1, 5'd1, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0);  // load r7
    tick();
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd10, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL load_use_stall: got stall=%b, want 1", stall);
    end
    tick();
    #1;
    checks++;
    if (stall !== 1'b0 || ex_valid !== 1'b0 || stage_valid !== 2'b01) begin
      failures++;
      $display("FAIL load_use_bubble: got stall=%b ex_valid=%b stage_valid=%b, want 0/0/01",
               stall, ex_valid, stage_valid);
    end
    tick();
    idle();
    #1;
    checks++;
    if (ex_valid !== 1'b1 || sel_of(0) !== 2'b10) begin
      failures++;
      $display("FAIL load_use_fwd: got ex_valid=%b src0=%b, want 1/10", ex_valid, sel_of(0));
    end
`ifdef FWD_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== 32'd1) begin
      failures++;
      $display("FAIL perf_stall: got %0d, want 1", perf_stall_cnt);
    end
`endif
    drain();
  endtask

  task automatic test_zero_unused();
    drive(1'b1, 5'd1, 5'd1, 2'b01, 5'd4, 1'b1, 1'b1, 1'b0);  // load r4
    tick();
    drive(1'b1, 5'd0, 5'd4, 2'b01, 5'd11, 1'b1, 1'b0, 1'b0);  // r0 used, r4 unused
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL unused_no_stall: got stall=%b, want 0", stall);
    end
    tick();
    idle();
    #1;
    checks++;
    if (sel_of(0) !== 2'b11 || sel_of(1) !== 2'b00) begin
      failures++;
      $display("FAIL zero_unused_sel: got src0=%b src1=%b, want 11/00", sel_of(0), sel_of(1));
    end
    drain();
    // Load to r0 never stalls; r0 writes are not forwarded
    drive(1'b1, 5'd1, 5'd1, 2'b01, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd12, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL r0_load_no_stall: got stall=%b, want 0", stall);
    end
    drain();
    // Non-writing instruction occupies a slot but never matches
    drive(1'b1, 5'd1, 5'd1, 2'b01, 5'd6, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd6, 5'd6, 2'b11, 5'd13, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL nowrite_no_stall: got stall=%b, want 0", stall);
    end
    tick();
    idle();
    #1;
    checks++;
    if (fwd_sel !== 4'b0000 || stage_valid !== 2'b01) begin
      failures++;
      $display("FAIL nowrite_no_fwd: got fwd_sel=%b stage_valid=%b, want 0000/01",
               fwd_sel, stage_valid);
    end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd1, 5'd1, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0);  // load r2
    tick();
    drive(1'b1, 5'd2, 5'd0, 2'b01, 5'd14, 1'b1, 1'b0, 1'b1);  // hazard + flush
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall: got stall=%b, want 0", stall);
    end
    tick();
    idle();
    #1;
    checks++;
    if (ex_valid !== 1'b0 || stage_valid !== 2'b01) begin
      failures++;
      $display("FAIL flush_bubble: got ex_valid=%b stage_valid=%b, want 0/01", ex_valid, stage_valid);
    end
    drain();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd1, 5'd1, 2'b01, 5'd9, 1'b1, 1'b1, 1'b0);  // load r9
    tick();
    drive(1'b1, 5'd0, 5'd9, 2'b10, 5'd15, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall !== 1'b1 || ex_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_stall: got stall=%b ex_valid=%b, want 1/1", stall, ex_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || ex_valid !== 1'b0 || stage_valid !== 2'b00) begin
      failures++;
      $display("FAIL async_reset: got stall=%b ex_valid=%b stage_valid=%b, want 0/0/00",
               stall, ex_valid, stage_valid);
    end
`ifdef FWD_PERF_CNT_EN
    checks++;
    if (perf_stall_cnt !== 32'd0 || perf_fwd_cnt !== 32'd0) begin
      failures++;
      $display("FAIL async_reset_perf: got %0d/%0d, want 0/0", perf_stall_cnt, perf_fwd_cnt);
    end
`endif
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_back_to_back();
    test_two_ago();
    test_load_use();
    test_zero_unused();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
Parametrised successor to the two-stage forwarding mux-select logic. It owns an internal shift pipeline of in-flight writer records for the EX slot plus DEPTH downstream stages. It computes per-source forwarding selects for the instruction in EX across any number of sources and stages. It also detects load-use hazards, generating the ID/IF stall and the EX bubble, and sits between the ID/EX boundary and the ALU operand muxes.

Parameters:
RA_W, 5, register address width
NUM_SRC, 2, source operands per instruction
DEPTH, 2, forwarding stages after EX (1 = EX/MEM, DEPTH = oldest, e.g. MEM/WB)
LOAD_LAT, 1, stall cycles a load needs before its result is forwardable (1..DEPTH)
SEL_W (localparam), $clog2(DEPTH+2), select width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a valid instruction
id_src  in  NUM_SRC*RA_W  ID source register addresses, source i at [i*RA_W +: RA_W]
id_src_used  in  NUM_SRC  per-source "operand actually read" mask
id_rd  in  RA_W  ID destination register
id_reg_write  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
flush  in  1  squash ID and insert bubble into EX
stall  out  1  hold PC and IF/ID this cycle
fwd_sel  out  NUM_SRC*SEL_W  per-source select for EX instruction
ex_valid  out  1  EX slot holds a valid instruction
stage_valid  out  DEPTH  valid writer in downstream stage k (bit k-1)

Behaviour:
- Reset (rst_n low, async): all slot valid/reg_write/is_load = 0, addresses 0. Outputs: stall=0, fwd_sel all 0, ex_valid=0, stage_valid=0.
- Slots: EX slot (sources, used mask, rd, reg_write, is_load, valid) plus stages 1..DEPTH (rd, reg_write, is_load, valid).
- Each clk: stage k <- stage k-1 (stage 1 <- EX slot). Downstream stages never stall.
- EX slot load rules:
  - flush: EX slot <- bubble.
  - stall: EX slot <- bubble.
  - otherwise: EX slot <- ID fields, with valid = id_valid.
- Bubble: valid=0, reg_write=0.
- fwd_sel, combinational from registered state only (zero comb path from id_* to fwd_sel), per source i:
  - EX slot invalid or source i unused: 0 (register file).
  - src == 0: DEPTH+1 (constant zero operand).
  - Else: smallest k in 1..DEPTH where stage k valid & reg_write & rd == src & rd != 0, giving k. Youngest wins.
  - Else: 0.
  - With DEPTH=2 the codes are 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 zero.
- stall, combinational. Asserted when id_valid & !flush and some used ID source s != 0 equals rd of a valid reg_write load in:
  - the EX slot, or
  - stages 1..LOAD_LAT-1.
- Load-use latency: LOAD_LAT=1 yields exactly one bubble. Each extra LOAD_LAT adds one stall cycle.
- Simultaneous flush & hazard: flush wins, stall=0.
- Writes to r0 are never forwarded and never stall.
- id_reg_write=0 instructions occupy slots but never match.
- Reset mid-stall: all slots clear immediately; stall drops asynchronously with rst_n low.

Optional Feature:
FWD_PERF_CNT_EN. When defined, two extra outputs are added:
- perf_stall_cnt (32): increments each cycle stall=1.
- perf_fwd_cnt (32): increments each cycle at least one fwd_sel is in 1..DEPTH.
- Both reset to 0 asynchronously, saturate at 32'hFFFF_FFFF, and are not cleared by flush.
When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Back-to-back ALU dependency: add r3 (writes r3), then next instruction reads src0=r3 -> one cycle later fwd_sel[0]=01, stall=0.
- Two-ago dependency with younger overwrite: writes r5, writes r5, reader src1=r5 -> fwd_sel[1]=01 (youngest), not 10.
- Load-use, LOAD_LAT=1: load r7 in EX, ID reads r7 -> stall=1 for exactly 1 cycle, ex_valid=0 next cycle, then fwd_sel[0]=10.
- Zero and unused sources: src0=r0 -> 11. src1=r4 with id_src_used[1]=0 while r4 is in flight -> 00, no stall.
- Flush during hazard: load r2 in EX, ID reads r2, flush=1 -> stall=0, EX slot bubble next cycle, stage_valid bit0=1 for the load.
- Async reset mid-stall: assert rst_n=0 while stall=1 -> stall, ex_valid, stage_valid=0 before next clk edge. With FWD_PERF_CNT_EN, counters read 0.
